// File: rtl/fsmc_read_port.sv
// rtl/fsmc_read_port.sv - FSMC read-back responder: register map, status byte and event FIFO
module fsmc_read_port #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              CLK_IN,
  input  logic              RESET,
  input  logic              FSMC_nCS,
  input  logic              FSMC_NOE,
  input  logic [ADDR_W-1:0] FSMC_ADD,
  output logic [DATA_W-1:0] FSMC_DATAOUT,
  output logic              FSMC_DATA_OE,
  input  logic [DATA_W-1:0] R1,
  input  logic [DATA_W-1:0] R2,
  input  logic [DATA_W-1:0] R3,
  input  logic [DATA_W-1:0] PUSH_DATA,
  input  logic              PUSH_VALID,
  output logic              PUSH_READY,
  output logic [4:0]        FIFO_COUNT
);

  localparam int         PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t            state;
  logic              cs_meta, cs_s, noe_meta, noe_s;
  logic              rd_act;
  logic [ADDR_W-1:0] addr_q;
  logic              pop_armed;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              ovf;
  logic              full, empty, push, drop, read_end, pop, clr_ovf;
  logic [4:0]        count_next;
  logic [7:0]        status;
  logic [DATA_W-1:0] map_data;

  // Two-flop synchronizers for the asynchronous bus strobes; reset to the idle (high) level
  always_ff @(posedge CLK_IN or negedge RESET) begin
    if (!RESET) begin
      {cs_meta, cs_s, noe_meta, noe_s} <= '1;
    end else begin
      cs_meta  <= FSMC_nCS;
      cs_s     <= cs_meta;
      noe_meta <= FSMC_NOE;
      noe_s    <= noe_meta;
    end
  end

  assign rd_act   = !cs_s && !noe_s;
  assign full     = (FIFO_COUNT == DEPTH_C);
  assign empty    = (FIFO_COUNT == 5'd0);
  assign push     = PUSH_VALID && PUSH_READY;
  assign drop     = PUSH_VALID && !PUSH_READY;
  assign read_end = (state == DRIVE) && !rd_act;
  assign pop      = read_end && pop_armed;
  assign clr_ovf  = read_end && (addr_q == ADDR_W'(3));
  assign status   = {full, empty, ovf, FIFO_COUNT};

  // Address map decode, sampled only at the start of a read
  always_comb begin
    map_data = '0;
    case (FSMC_ADD)
      ADDR_W'(0): map_data = R1;
      ADDR_W'(1): map_data = R2;
      ADDR_W'(2): map_data = R3;
      ADDR_W'(3): map_data = DATA_W'(status);
      ADDR_W'(4): map_data = empty ? '0 : mem[rd_ptr];
      default:    map_data = '0;
    endcase
  end

  // Read FSM: latch address and data on read start, hold them for the whole strobe
  always_ff @(posedge CLK_IN or negedge RESET) begin
    if (!RESET) begin
      state        <= IDLE;
      addr_q       <= '0;
      pop_armed    <= 1'b0;
      FSMC_DATAOUT <= '0;
      FSMC_DATA_OE <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_act) begin
            addr_q       <= FSMC_ADD;
            // an empty-FIFO read must not pop an entry pushed later during the strobe
            pop_armed    <= (FSMC_ADD == ADDR_W'(4)) && !empty;
            FSMC_DATAOUT <= map_data;
            FSMC_DATA_OE <= 1'b1;
            state        <= DRIVE;
          end
        end
        DRIVE: begin
          if (!rd_act) begin
            FSMC_DATA_OE <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Occupancy after this cycle's push and read-end pop
  always_comb begin
    count_next = FIFO_COUNT;
    if (push && !pop) begin
      count_next = FIFO_COUNT + 5'd1;
    end else if (pop && !push) begin
      count_next = FIFO_COUNT - 5'd1;
    end
  end

  // FIFO pointers, occupancy, ready flag and sticky overflow (set beats clear)
  always_ff @(posedge CLK_IN or negedge RESET) begin
    if (!RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      FIFO_COUNT <= 5'd0;
      PUSH_READY <= 1'b1;
      ovf        <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      FIFO_COUNT <= count_next;
      PUSH_READY <= (count_next != DEPTH_C);
      if (drop) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  // FIFO storage; contents are don't-care until written, pointers define validity
  always_ff @(posedge CLK_IN) begin
    if (push) mem[wr_ptr] <= PUSH_DATA;
  end

endmodule

// File: tb/tb_fsmc_read_port.sv
// tb/tb_fsmc_read_port.sv - self-checking bench for fsmc_read_port
module tb_fsmc_read_port;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ncs, noe;
  logic [3:0] add;
  logic [7:0] r1, r2, r3;
  logic [7:0] push_data;
  logic       push_valid;
  logic [7:0] dout;
  logic       oe;
  logic       ready;
  logic [4:0] count;

  always #5 clk = ~clk;

  fsmc_read_port #(.DATA_W(8), .ADDR_W(4), .FIFO_DEPTH(DEPTH)) dut (
    .CLK_IN      (clk),
    .RESET       (rst_n),
    .FSMC_nCS    (ncs),
    .FSMC_NOE    (noe),
    .FSMC_ADD    (add),
    .FSMC_DATAOUT(dout),
    .FSMC_DATA_OE(oe),
    .R1          (r1),
    .R2          (r2),
    .R3          (r3),
    .PUSH_DATA   (push_data),
    .PUSH_VALID  (push_valid),
    .PUSH_READY  (ready),
    .FIFO_COUNT  (count)
  );

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [7:0] q[$];
  bit         m_ovf;
  bit         m_drive;
  bit         m_pop;
  logic [3:0] m_addr;
  logic [7:0] m_data;
  int         lo_cnt;
  int         hi_cnt;
  bit         rand_push;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] map_val(input logic [3:0] a);
    int n;
    n = q.size();
    case (a)
      4'h0:    return r1;
      4'h1:    return r2;
      4'h2:    return r3;
      4'h3:    return {n == DEPTH, n == 0, m_ovf, 5'(n)};
      4'h4:    return (n > 0) ? q[0] : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf   = 0;
    m_drive = 0;
    m_pop   = 0;
    m_addr  = 4'h0;
    m_data  = 8'h00;
    lo_cnt  = 0;
    hi_cnt  = 0;
  endtask

  // one rising edge of the reference: read start 3 edges into a low strobe, read end 3 edges into a high one
  task automatic model_edge();
    bit latch, fin, do_push, do_drop;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!ncs && !noe) begin
      lo_cnt++;
      hi_cnt = 0;
    end else begin
      hi_cnt++;
      lo_cnt = 0;
    end
    latch   = !m_drive && (lo_cnt >= 3);
    fin     = m_drive && (hi_cnt >= 3);
    do_push = push_valid && (q.size() < DEPTH);
    do_drop = push_valid && (q.size() == DEPTH);
    if (latch) begin
      m_data  = map_val(add);
      m_addr  = add;
      m_pop   = (add == 4'h4) && (q.size() > 0);
      m_drive = 1;
    end
    if (fin) begin
      m_drive = 0;
      if (m_pop) void'(q.pop_front());
      if (m_addr == 4'h3) m_ovf = 0;
    end
    if (do_push) q.push_back(push_data);
    if (do_drop) m_ovf = 1;
  endtask

  task automatic step();
    if (rand_push) begin
      push_valid = ($urandom_range(0, 3) == 0);
      push_data  = 8'($urandom);
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("oe", oe, m_drive);
    check("dout", dout, m_data);
    check("count", count, q.size());
    check("ready", ready, q.size() < DEPTH);
  endtask

  task automatic push(input logic [7:0] d);
    push_valid = 1;
    push_data  = d;
    step();
    push_valid = 0;
  endtask

  task automatic read_begin(input logic [3:0] a);
    add = a;
    ncs = 0;
    noe = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("oe_rise", oe, i == 3);
    end
  endtask

  task automatic read_end(input bit push_at_end, input logic [7:0] pd);
    ncs = 1;
    noe = 1;
    for (int i = 1; i <= 3; i++) begin
      if (push_at_end && i == 3) begin
        push_valid = 1;
        push_data  = pd;
      end
      step();
      if (push_at_end && i == 3) push_valid = 0;
      check("oe_fall", oe, i < 3);
    end
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    read_begin(a);
    step();
    d = dout;
    read_end(0, 8'h00);
  endtask

  task automatic expect_read(input string tag, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  initial begin
    logic [7:0] d;
    logic [3:0] a;
    rst_n      = 0;
    ncs        = 1;
    noe        = 1;
    add        = 4'h0;
    r1         = 8'h00;
    r2         = 8'h00;
    r3         = 8'h00;
    push_data  = 8'h00;
    push_valid = 0;
    rand_push  = 0;
    model_reset();

    // reset state
    @(negedge clk);
    repeat (2) step();
    check("rst_oe", oe, 1'b0);
    check("rst_dout", dout, 8'h00);
    check("rst_ready", ready, 1'b1);
    check("rst_count", count, 5'd0);
    rst_n = 1;
    repeat (2) step();

    // register read
    r1 = 8'hA5; r2 = 8'h3C; r3 = 8'h0F;
    expect_read("reg_r1", 4'h0, 8'hA5);
    expect_read("reg_r2", 4'h1, 8'h3C);
    expect_read("reg_r3", 4'h2, 8'h0F);
    expect_read("reg_unmapped", 4'h7, 8'h00);

    // hold during read
    r1 = 8'h11;
    read_begin(4'h0);
    step();
    r1 = 8'h22;
    repeat (3) begin
      step();
      check("hold", dout, 8'h11);
    end
    read_end(0, 8'h00);
    expect_read("after_hold", 4'h0, 8'h22);

    // FIFO order and wrap
    for (int i = 1; i <= 16; i++) push(8'(i));
    check("full_count", count, 5'd16);
    check("full_ready", ready, 1'b0);
    expect_read("status_full", 4'h3, 8'h90);
    for (int i = 1; i <= 16; i++) expect_read("fifo_order", 4'h4, 8'(i));
    check("empty_count", count, 5'd0);
    expect_read("status_empty", 4'h3, 8'h40);
    push(8'h55);
    expect_read("fifo_wrap", 4'h4, 8'h55);

    // overflow and empty
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    push(8'hEE);
    expect_read("ovf_status", 4'h3, 8'hB0);
    expect_read("ovf_cleared", 4'h3, 8'h90);
    for (int i = 0; i < 16; i++) expect_read("ovf_drain", 4'h4, 8'h20 + 8'(i));
    expect_read("empty_read", 4'h4, 8'h00);
    check("empty_read_count", count, 5'd0);

    // push in the same cycle a pop completes
    push(8'hA1); push(8'hA2); push(8'hA3);
    read_begin(4'h4);
    step();
    d = dout;
    read_end(1, 8'hA4);
    check("sim_pop_data", d, 8'hA1);
    check("sim_count", count, 5'd3);
    expect_read("sim_order_b", 4'h4, 8'hA2);
    expect_read("sim_order_c", 4'h4, 8'hA3);
    expect_read("sim_order_d", 4'h4, 8'hA4);

    // overflow in the same cycle a status read ends
    for (int i = 0; i < 16; i++) push(8'h30 + 8'(i));
    read_begin(4'h3);
    step();
    d = dout;
    read_end(1, 8'hEE);
    check("sim_status_first", d, 8'h90);
    expect_read("sim_ovf_wins", 4'h3, 8'hB0);
    for (int i = 0; i < 16; i++) expect_read("sim_drain", 4'h4, 8'h30 + 8'(i));

    // reset mid-read
    push(8'hC1); push(8'hC2); push(8'hC3);
    read_begin(4'h4);
    step();
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check("rst_mid_oe", oe, 1'b0);
    check("rst_mid_dout", dout, 8'h00);
    ncs = 1;
    noe = 1;
    step();
    rst_n = 1;
    repeat (3) step();
    check("rst_mid_count", count, 5'd0);
    expect_read("rst_mid_status", 4'h3, 8'h40);

    // randomized traffic against the model
    rand_push = 1;
    for (int n = 0; n < 150; n++) begin
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      r3 = 8'($urandom);
      a  = ($urandom_range(0, 2) == 0) ? 4'h4 : 4'($urandom_range(0, 15));
      bus_read(a, d);
      check("rand_read", d, m_data);
      repeat ($urandom_range(0, 3)) step();
    end
    rand_push  = 0;
    push_valid = 0;
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsmc_read_port.md
# fsmc_read_port

FSMC read-back responder for the CPU bus: drives data onto the external bus when the CPU reads an FPGA address, the reverse direction of the existing FSMC register-write path. It exposes three 8-bit application registers, a status byte and an 8-bit-wide event FIFO that is popped by CPU reads. It sits beside the write decoders in the CPU bus block and feeds the top-level bidirectional data pads through a separate output-enable.

## Interface
- DATA_W, 8, bus and register data width
- ADDR_W, 4, FSMC address width
- FIFO_DEPTH, 16, event FIFO entries (power of 2, 2..16)

- CLK_IN  input  1  system clock, all logic on rising edge
- RESET  input  1  asynchronous, active-low reset
- FSMC_nCS  input  1  chip select, active low, asynchronous to CLK_IN
- FSMC_NOE  input  1  output enable (read strobe), active low, asynchronous
- FSMC_ADD  input  ADDR_W  read address; stable while FSMC_nCS is low
- FSMC_DATAOUT  output  DATA_W  read data toward the pads
- FSMC_DATA_OE  output  1  high = FPGA drives the data pads
- R1, R2, R3  input  DATA_W each  application registers to read back
- PUSH_DATA  input  DATA_W  event FIFO write data
- PUSH_VALID  input  1  write request, qualified by PUSH_READY
- PUSH_READY  output  1  high when the FIFO is not full
- FIFO_COUNT  output  5  current occupancy, 0..FIFO_DEPTH

## Operation
- FSMC_nCS and FSMC_NOE each pass through a 2-flop synchronizer. rd_act = !cs_s && !noe_s.
- Address map:
  - 0x0: R1
  - 0x1: R2
  - 0x2: R3
  - 0x3: STATUS = {full, empty, ovf, count[4:0]}
  - 0x4: FIFO head
  - all other addresses: 0x00
- State machine:
  - IDLE: FSMC_DATA_OE = 0. When rd_act = 1, latch FSMC_ADD, load FSMC_DATAOUT from the address map, and go to DRIVE.
  - DRIVE: FSMC_DATA_OE = 1 and FSMC_DATAOUT is held constant, even if R1–R3 or the FIFO change. When rd_act = 0, apply the read side effect and go to IDLE.
- Read side effects are applied only at read end, so the driven data never changes mid-read:
  - A completed read of 0x4 pops one entry.
  - A completed read of 0x3 clears ovf.
- FIFO behaviour:
  - Push occurs when PUSH_VALID && PUSH_READY.
  - Push while full: data is dropped and ovf is set (sticky).
  - Pop while empty: the read returns 0x00, with no pointer or count change.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
- Simultaneous ovf set and clear-by-status-read in the same cycle: set wins, ovf = 1.
- Reset values:
  - FSMC_DATAOUT = 0x00, FSMC_DATA_OE = 0, PUSH_READY = 1, FIFO_COUNT = 0.
  - ovf = 0, pointers = 0, state = IDLE, synchronizers = 1 (bus idle).
- Reset asserted mid-read: FSMC_DATA_OE drops to 0 immediately (asynchronous), no pop occurs, and FIFO contents are discarded.

## Timing
- FSMC_DATA_OE and FSMC_DATAOUT are both registered outputs. They are valid at the 3rd rising edge of CLK_IN from the first edge that samples FSMC_NOE low with FSMC_nCS low.
- FSMC_DATA_OE deasserts at the 3rd edge after FSMC_NOE or FSMC_nCS returns high. The pop or ovf clear takes effect at that same edge.
- The CPU's read strobe low time must be at least 4 CLK_IN periods, and the data setup allowance must cover 3 periods plus pad delay. This is a firmware timing constraint, not checked by the block.
- FIFO status:
  - PUSH_READY and FIFO_COUNT are registered.
  - A push is visible in FIFO_COUNT at the following edge.
  - A push is readable at 0x4 for any read whose IDLE→DRIVE transition occurs at least one edge after the push.
- Back-to-back reads require FSMC_NOE to be high for at least 3 CLK_IN edges, so the block re-enters IDLE between reads.

## Test plan
- Register read:
  - Stimulus: reset, then R1 = 0xA5, R2 = 0x3C, R3 = 0x0F; read 0x0, 0x1, 0x2, 0x7.
  - Required: data 0xA5, 0x3C, 0x0F, 0x00. FSMC_DATA_OE rises 3 edges after NOE falls and is low 3 edges after NOE rises.
- Hold during read:
  - Stimulus: start a read of 0x0 with R1 = 0x11, change R1 to 0x22 mid-read, then read 0x0 again.
  - Required: first read stays 0x11 for its whole duration; second read returns 0x22.
- FIFO order and wrap:
  - Stimulus: push 0x01..0x10 (16 entries), then read 0x4 sixteen times, then push 0x55 and read 0x4.
  - Required: reads return 0x01..0x10 then 0x55. FIFO_COUNT goes 16→0; STATUS shows full at 16, empty at 0.
- Overflow and empty:
  - Stimulus: fill the FIFO, push 0xEE, read 0x3, read 0x3 again, then drain and read 0x4 once more.
  - Required: first status = 0xB0 (full, ovf, count 16); second shows ovf = 0; 0xEE never appears; the empty read returns 0x00 with FIFO_COUNT staying 0.
- Simultaneous events:
  - Stimulus: push in the same cycle as a pop completes; separately, overflow in the same cycle as a status-read end.
  - Required: count unchanged with correct order preserved; ovf = 1.
- Reset mid-read:
  - Stimulus: assert RESET while in DRIVE on a 0x4 read with 3 entries.
  - Required: FSMC_DATA_OE = 0 and FSMC_DATAOUT = 0x00 immediately; after release, FIFO_COUNT = 0 and STATUS = 0x40.
